// File: rtl/snake_grid_renderer.sv
// Snake grid renderer: 640x480@60 VGA timing, grid RAM addressing, cell-code to RGB444 colour mapping (optional grid lines: SNAKE_GRID_LINES_EN).
// Latency: pixel outputs for counter position (h,v) appear 2 rclk later; frame_tick appears 1 rclk after (0,V_ACTIVE).
// Backpressure: none; free-running in the pixel clock domain, and the RAM must return data one rclk after raddr is registered.
module snake_grid_renderer #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          CELL_SHIFT = 5,
    parameter int          GRID_X0    = 192,
    parameter int          GRID_Y0    = 112,
    parameter logic [11:0] BG_COLOR   = 12'h111
) (
    input  logic        rclk,
    input  logic        rst_n,
    output logic [5:0]  raddr,
    input  logic [1:0]  rdata,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] rgb,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int GRID_PX = 8 << CELL_SHIFT;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] GX0    = HW'(GRID_X0);
    localparam logic [HW-1:0] GX1    = HW'(GRID_X0 + GRID_PX - 1);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] GY0    = VW'(GRID_Y0);
    localparam logic [VW-1:0] GY1    = VW'(GRID_Y0 + GRID_PX - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    // stage 0: decode of the current counter position
    logic       act;
    logic       in_grid;
    logic       hs;
    logic       vs;
    logic [2:0] col;
    logic [2:0] row;
    logic [5:0] addr_nxt;

    // stage 1: travels alongside the RAM read
    logic act_s1;
    logic grid_s1;
    logic hs_s1;
    logic vs_s1;

    logic [11:0] color;

    always_comb begin
        act      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        in_grid  = act && (h_cnt >= GX0) && (h_cnt <= GX1) && (v_cnt >= GY0) && (v_cnt <= GY1);
        hs       = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
        vs       = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
        col      = 3'((h_cnt - GX0) >> CELL_SHIFT);
        row      = 3'((v_cnt - GY0) >> CELL_SHIFT);
        addr_nxt = in_grid ? {row, col} : 6'd0;
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // sync flags reset to their idle (high) level so no false pulse follows release
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            raddr      <= 6'd0;
            act_s1     <= 1'b0;
            grid_s1    <= 1'b0;
            hs_s1      <= 1'b1;
            vs_s1      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            raddr      <= addr_nxt;
            act_s1     <= act;
            grid_s1    <= in_grid;
            hs_s1      <= hs;
            vs_s1      <= vs;
            frame_tick <= (h_cnt == '0) && (v_cnt == V_ACT);
        end
    end

`ifdef SNAKE_GRID_LINES_EN
    logic line_nxt;
    logic line_s1;

    always_comb begin
        line_nxt = in_grid &&
                   ((CELL_SHIFT'(h_cnt - GX0) == '0) || (CELL_SHIFT'(v_cnt - GY0) == '0));
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            line_s1 <= 1'b0;
        end else begin
            line_s1 <= line_nxt;
        end
    end
`endif

    always_comb begin
        color = 12'h000;
        if (!act_s1) begin
            color = 12'h000;
        end else if (!grid_s1) begin
            color = BG_COLOR;
        end else begin
            case (rdata)
                2'b00:   color = 12'h000;
                2'b01:   color = 12'h0F0;
                2'b10:   color = 12'hF00;
                default: color = 12'hFF0;
            endcase
`ifdef SNAKE_GRID_LINES_EN
            if (line_s1) begin
                color = 12'h444;
            end
`endif
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
            rgb   <= 12'h000;
        end else begin
            hsync <= hs_s1;
            vsync <= vs_s1;
            de    <= act_s1;
            rgb   <= color;
        end
    end

endmodule
